// File: rtl/ipf_feeder_if.sv
// Bundle of the SRAM read port and the IPF stream/control/status signals driven or observed by ipf_feeder.
// master = the feeder; slave = the memory + IPF side.
interface ipf_feeder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic [DATA_W-1:0] w_data;
    logic              w_valid;
    logic [1:0]        ctrl;
    logic              res_valid;
    logic              ipf_finish;

    modport master (
        output mem_rd, mem_addr, i_data, i_valid, w_data, w_valid, ctrl,
        input  mem_rdata, res_valid, ipf_finish
    );

    modport slave (
        input  mem_rd, mem_addr, i_data, i_valid, w_data, w_valid, ctrl,
        output mem_rdata, res_valid, ipf_finish
    );
endinterface

// File: rtl/ipf_feeder.sv
// Tile sequencer for the IPF multiply engine: per tile loads input rows and weights from SRAM, then one compute burst.
// Optional feature: define IPF_FEEDER_PERF_EN to add the perf_cycles busy-cycle counter output.
module ipf_feeder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 64,
    parameter int I_WORDS    = 8,
    parameter int W_WORDS    = 4,
    parameter int RUN_CYCLES = 32,
    parameter int TILE_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_i_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [TILE_W-1:0] cfg_tiles,
    output logic              busy,
    output logic              done,
    output logic              err,
    ipf_feeder_if.master      bus
`ifdef IPF_FEEDER_PERF_EN
   ,output logic [31:0]       perf_cycles
`endif
);

    localparam int CNT_MAX_IW = (I_WORDS > W_WORDS) ? I_WORDS : W_WORDS;
    localparam int CNT_MAX    = (RUN_CYCLES > CNT_MAX_IW) ? RUN_CYCLES : CNT_MAX_IW;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] CTRL_END   = 2'd0;
    localparam logic [1:0] CTRL_START = 2'd1;
    localparam logic [1:0] CTRL_HOLD  = 2'd2;
    localparam logic [1:0] CTRL_NOP   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_W,
        S_DRAIN,
        S_KICK,
        S_RUN,
        S_HOLD,
        S_FIN,
        S_WAIT_FIN
    } state_t;

    state_t            r_state;
    logic [1:0]        r_ctrl;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_i_ptr;
    logic [ADDR_W-1:0] r_w_ptr;
    logic [TILE_W-1:0] r_tiles;
    logic [TILE_W-1:0] r_tile;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_rd_d1;
    logic              r_rd_w_d1;
    logic              r_i_valid;
    logic              r_w_valid;
    logic [DATA_W-1:0] r_i_data;
    logic [DATA_W-1:0] r_w_data;

    logic              w_accept;
    logic              w_res_low;
    logic              w_res_high;
    logic              w_fin_early;
    logic              w_err_hit;
    logic [TILE_W:0]   w_tile_nx;
    logic              w_more_tiles;

    assign w_accept = (r_state == S_IDLE) && cfg_start && (cfg_tiles != '0);

    // The first RUN cycle is exempt: IPF needs one cycle after START before results appear.
    assign w_res_low   = (((r_state == S_RUN) && (r_cnt != '0)) || (r_state == S_HOLD)) && !bus.res_valid;
    assign w_res_high  = ((r_state == S_LOAD_I) || (r_state == S_LOAD_W) || (r_state == S_DRAIN)) && bus.res_valid;
    assign w_fin_early = ((r_state == S_LOAD_I) || (r_state == S_LOAD_W) || (r_state == S_DRAIN) ||
                          (r_state == S_KICK)   || (r_state == S_RUN)    || (r_state == S_HOLD)) && bus.ipf_finish;
    assign w_err_hit   = w_res_low || w_res_high || w_fin_early;

    assign w_tile_nx    = {1'b0, r_tile} + {{TILE_W{1'b0}}, 1'b1};
    assign w_more_tiles = w_tile_nx < {1'b0, r_tiles};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ctrl     <= CTRL_NOP;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_i_ptr    <= '0;
            r_w_ptr    <= '0;
            r_tiles    <= '0;
            r_tile     <= '0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_err_hit) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_tiles != '0) begin
                            r_state    <= S_LOAD_I;
                            r_busy     <= 1'b1;
                            r_tiles    <= cfg_tiles;
                            r_tile     <= '0;
                            r_cnt      <= '0;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= cfg_i_base;
                            r_i_ptr    <= cfg_i_base + ADDR_W'(1);
                            r_w_ptr    <= cfg_w_base;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                // Read pointers run continuously across tiles, so tile t starts at base + t*WORDS.
                S_LOAD_I: begin
                    if (r_cnt == CNT_W'(I_WORDS - 1)) begin
                        r_state    <= S_LOAD_W;
                        r_cnt      <= '0;
                        r_mem_addr <= r_w_ptr;
                        r_w_ptr    <= r_w_ptr + ADDR_W'(1);
                    end else begin
                        r_cnt      <= r_cnt + CNT_W'(1);
                        r_mem_addr <= r_i_ptr;
                        r_i_ptr    <= r_i_ptr + ADDR_W'(1);
                    end
                end
                S_LOAD_W: begin
                    if (r_cnt == CNT_W'(W_WORDS - 1)) begin
                        r_state    <= S_DRAIN;
                        r_cnt      <= '0;
                        r_mem_rd   <= 1'b0;
                        r_mem_addr <= '0;
                    end else begin
                        r_cnt      <= r_cnt + CNT_W'(1);
                        r_mem_addr <= r_w_ptr;
                        r_w_ptr    <= r_w_ptr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_KICK;
                        r_ctrl  <= CTRL_START;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_KICK: begin
                    r_state <= S_RUN;
                    r_ctrl  <= CTRL_NOP;
                    r_cnt   <= '0;
                end
                S_RUN: begin
                    if (r_cnt == CNT_W'(RUN_CYCLES - 2)) begin
                        r_state <= S_HOLD;
                        r_ctrl  <= CTRL_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_more_tiles) begin
                        r_state    <= S_LOAD_I;
                        r_ctrl     <= CTRL_NOP;
                        r_tile     <= w_tile_nx[TILE_W-1:0];
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_i_ptr;
                        r_i_ptr    <= r_i_ptr + ADDR_W'(1);
                    end else begin
                        r_state <= S_FIN;
                        r_ctrl  <= CTRL_END;
                    end
                end
                S_FIN: begin
                    r_state <= S_WAIT_FIN;
                    r_ctrl  <= CTRL_NOP;
                end
                S_WAIT_FIN: begin
                    if (bus.ipf_finish) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ctrl  <= CTRL_NOP;
                end
            endcase
        end
    end

    // Read data lands one cycle after mem_rd; tag it by source so only one stream is ever valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_d1   <= 1'b0;
            r_rd_w_d1 <= 1'b0;
            r_i_valid <= 1'b0;
            r_w_valid <= 1'b0;
            r_i_data  <= '0;
            r_w_data  <= '0;
        end else begin
            r_rd_d1   <= r_mem_rd;
            r_rd_w_d1 <= (r_state == S_LOAD_W);
            r_i_valid <= r_rd_d1 && !r_rd_w_d1;
            r_w_valid <= r_rd_d1 && r_rd_w_d1;
            r_i_data  <= (r_rd_d1 && !r_rd_w_d1) ? bus.mem_rdata : '0;
            r_w_data  <= (r_rd_d1 && r_rd_w_d1)  ? bus.mem_rdata : '0;
        end
    end

`ifdef IPF_FEEDER_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_addr = r_mem_addr;
    assign bus.i_data   = r_i_data;
    assign bus.i_valid  = r_i_valid;
    assign bus.w_data   = r_w_data;
    assign bus.w_valid  = r_w_valid;
    assign bus.ctrl     = r_ctrl;

endmodule

// File: tb/tb_ipf_feeder.sv
// Directed bench for ipf_feeder with a sync-read SRAM model and a minimal IPF responder.
module tb_ipf_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_i_base = '0;
    logic [15:0] cfg_w_base = '0;
    logic [7:0]  cfg_tiles = '0;
    logic        busy;
    logic        done;
    logic        err;
`ifdef IPF_FEEDER_PERF_EN
    logic [31:0] perf_cycles;
`endif

    ipf_feeder_if #(.ADDR_W(16), .DATA_W(64)) bus ();

    ipf_feeder #(
        .ADDR_W(16), .DATA_W(64), .I_WORDS(8), .W_WORDS(4), .RUN_CYCLES(32), .TILE_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_i_base (cfg_i_base),
        .cfg_w_base (cfg_w_base),
        .cfg_tiles  (cfg_tiles),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (bus)
`ifdef IPF_FEEDER_PERF_EN
       ,.perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [15:0] a);
        return {a, ~a, 16'hC0DE, a ^ 16'h5A5A};
    endfunction

    // SRAM: data for the address presented with mem_rd is available the following cycle
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem_word(bus.mem_addr);
    end

    // IPF responder: computes between START and HOLD, finishes the cycle after END
    logic ipf_compute;
    logic force_res_low = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ipf_compute    <= 1'b0;
            bus.ipf_finish <= 1'b0;
        end else begin
            if (bus.ctrl == 2'd1)      ipf_compute <= 1'b1;
            else if (bus.ctrl == 2'd2) ipf_compute <= 1'b0;
            bus.ipf_finish <= (bus.ctrl == 2'd0);
        end
    end
    assign bus.res_valid = ipf_compute & ~force_res_low;

    // Monitor, sampled on the falling edge
    int cyc = 0;
    int n_rd, n_iv, n_wv, n_overlap, n_start, n_hold, n_end, n_done, n_busy, n_badrun, n_ctrl_act;
    int since, last_run, first_rd, first_iv, last_iv, first_wv;
    bit in_run;
    logic [15:0] q_addr[$];
    logic [63:0] q_i[$];
    logic [63:0] q_w[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.mem_rd) begin
            if (n_rd == 0) first_rd = cyc;
            n_rd++;
            q_addr.push_back(bus.mem_addr);
        end
        if (bus.i_valid) begin
            if (n_iv == 0) first_iv = cyc;
            last_iv = cyc;
            n_iv++;
            q_i.push_back(bus.i_data);
        end
        if (bus.w_valid) begin
            if (n_wv == 0) first_wv = cyc;
            n_wv++;
            q_w.push_back(bus.w_data);
        end
        if (bus.i_valid && bus.w_valid) n_overlap++;
        if (bus.ctrl != 2'd3) n_ctrl_act++;
        case (bus.ctrl)
            2'd1: begin n_start++; since = 0; in_run = 1'b1; end
            2'd2: begin
                n_hold++;
                last_run = since;
                if (since != 31) n_badrun++;
                in_run = 1'b0;
            end
            2'd0: n_end++;
            default: if (in_run) since++;
        endcase
        if (done) n_done++;
        if (busy) n_busy++;
    end

    task automatic mon_clear();
        n_rd = 0; n_iv = 0; n_wv = 0; n_overlap = 0; n_start = 0; n_hold = 0; n_end = 0;
        n_done = 0; n_busy = 0; n_badrun = 0; n_ctrl_act = 0; since = 0; last_run = 0;
        first_rd = 0; first_iv = 0; last_iv = 0; first_wv = 0; in_run = 1'b0;
        q_addr.delete(); q_i.delete(); q_w.delete();
    endtask

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tb_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_seq(input logic [15:0] ib, input logic [15:0] wb, input logic [7:0] tiles);
        cfg_i_base = ib;
        cfg_w_base = wb;
        cfg_tiles  = tiles;
        cfg_start  = 1'b1;
        tick(1);
        cfg_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            tick(1);
            k++;
        end
        tb_check({tag, "_done_seen"}, 64'(n_done != 0), 64'd1);
        tick(2);
    endtask

    task automatic check_seq(input string tag, input logic [15:0] ib, input logic [15:0] wb, input int tiles);
        logic [15:0] a;
        tb_check({tag, "_n_rd"}, 64'(n_rd), 64'(tiles * 12));
        tb_check({tag, "_n_ivalid"}, 64'(n_iv), 64'(tiles * 8));
        tb_check({tag, "_n_wvalid"}, 64'(n_wv), 64'(tiles * 4));
        tb_check({tag, "_overlap"}, 64'(n_overlap), 64'd0);
        for (int t = 0; t < tiles; t++) begin
            for (int k = 0; k < 8; k++) begin
                a = ib + 16'(t * 8 + k);
                tb_check({tag, "_iaddr"}, 64'(q_addr[t * 12 + k]), 64'(a));
                tb_check({tag, "_idata"}, q_i[t * 8 + k], mem_word(a));
            end
            for (int k = 0; k < 4; k++) begin
                a = wb + 16'(t * 4 + k);
                tb_check({tag, "_waddr"}, 64'(q_addr[t * 12 + 8 + k]), 64'(a));
                tb_check({tag, "_wdata"}, q_w[t * 4 + k], mem_word(a));
            end
        end
    endtask

    initial begin
        mon_clear();
        rst = 1'b0;
        tick(3);
        tb_check("rst_ctrl",    64'(bus.ctrl),     64'd3);
        tb_check("rst_busy",    64'(busy),         64'd0);
        tb_check("rst_done",    64'(done),         64'd0);
        tb_check("rst_err",     64'(err),          64'd0);
        tb_check("rst_mem_rd",  64'(bus.mem_rd),   64'd0);
        tb_check("rst_addr",    64'(bus.mem_addr), 64'd0);
        tb_check("rst_ivalid",  64'(bus.i_valid),  64'd0);
        tb_check("rst_wvalid",  64'(bus.w_valid),  64'd0);
        $display("[TB] reset state checked");
        rst = 1'b1;
        tick(2);

        // One tile
        mon_clear();
        start_seq(16'h0100, 16'h0200, 8'd1);
        tb_check("t1_busy_start", 64'(busy),         64'd1);
        tb_check("t1_rd_start",   64'(bus.mem_rd),   64'd1);
        tb_check("t1_addr_start", 64'(bus.mem_addr), 64'h0100);
        wait_done("t1", 200);
        check_seq("t1", 16'h0100, 16'h0200, 1);
        tb_check("t1_iv_latency", 64'(first_iv - first_rd), 64'd2);
        tb_check("t1_wv_latency", 64'(first_wv - first_rd), 64'd10);
        tb_check("t1_i_before_w", 64'(last_iv < first_wv),  64'd1);
        tb_check("t1_n_start",    64'(n_start),    64'd1);
        tb_check("t1_n_hold",     64'(n_hold),     64'd1);
        tb_check("t1_n_end",      64'(n_end),      64'd1);
        tb_check("t1_ctrl_act",   64'(n_ctrl_act), 64'd3);
        tb_check("t1_run_len",    64'(last_run),   64'd31);
        tb_check("t1_n_done",     64'(n_done),     64'd1);
        tb_check("t1_busy_cyc",   64'(n_busy),     64'd49);
        tb_check("t1_err",        64'(err),        64'd0);
        tb_check("t1_busy_end",   64'(busy),       64'd0);
        tb_check("t1_ctrl_end",   64'(bus.ctrl),   64'd3);
`ifdef IPF_FEEDER_PERF_EN
        tb_check("t1_perf_meas",  64'(perf_cycles), 64'(n_busy));
        tb_check("t1_perf_const", 64'(perf_cycles), 64'd49);
`endif
        $display("[TB] T1 one tile: reads=%0d busy_cycles=%0d", n_rd, n_busy);

        // Zero tiles
        mon_clear();
        start_seq(16'h1234, 16'h2345, 8'd0);
        tb_check("t2_done_next", 64'(done), 64'd1);
        tb_check("t2_busy",      64'(busy), 64'd0);
        tick(1);
        tb_check("t2_done_pulse", 64'(done), 64'd0);
        tick(5);
        tb_check("t2_n_rd",     64'(n_rd),       64'd0);
        tb_check("t2_n_iv",     64'(n_iv),       64'd0);
        tb_check("t2_n_wv",     64'(n_wv),       64'd0);
        tb_check("t2_ctrl_act", 64'(n_ctrl_act), 64'd0);
        tb_check("t2_n_done",   64'(n_done),     64'd1);
        tb_check("t2_n_busy",   64'(n_busy),     64'd0);
        $display("[TB] T2 zero tiles: done pulses=%0d", n_done);

        // Three tiles with input-address wrap
        mon_clear();
        start_seq(16'hFFF8, 16'h0010, 8'd3);
        wait_done("t3", 600);
        check_seq("t3", 16'hFFF8, 16'h0010, 3);
        tb_check("t3_wrap_addr", 64'(q_addr[12]), 64'h0000);
        tb_check("t3_n_start",   64'(n_start),  64'd3);
        tb_check("t3_n_hold",    64'(n_hold),   64'd3);
        tb_check("t3_n_end",     64'(n_end),    64'd1);
        tb_check("t3_badrun",    64'(n_badrun), 64'd0);
        tb_check("t3_busy_cyc",  64'(n_busy),   64'd143);
        tb_check("t3_err",       64'(err),      64'd0);
        $display("[TB] T3 three tiles: reads=%0d starts=%0d", n_rd, n_start);

        // Start pulse during RUN is ignored
        mon_clear();
        start_seq(16'h0300, 16'h0400, 8'd2);
        tick(24);
        tb_check("t4_in_run_busy", 64'(busy), 64'd1);
        start_seq(16'h7000, 16'h7100, 8'd5);
        wait_done("t4", 600);
        check_seq("t4", 16'h0300, 16'h0400, 2);
        tb_check("t4_n_start", 64'(n_start), 64'd2);
        tb_check("t4_n_end",   64'(n_end),   64'd1);
        tb_check("t4_err",     64'(err),     64'd0);
        $display("[TB] T4 start during RUN ignored: starts=%0d", n_start);

        // Reset mid-RUN, then a clean run
        mon_clear();
        start_seq(16'h0100, 16'h0200, 8'd1);
        tick(25);
        rst = 1'b0;
        tick(1);
        tb_check("t5_rst_ctrl",   64'(bus.ctrl),    64'd3);
        tb_check("t5_rst_busy",   64'(busy),        64'd0);
        tb_check("t5_rst_mem_rd", 64'(bus.mem_rd),  64'd0);
        tb_check("t5_rst_ivalid", 64'(bus.i_valid), 64'd0);
        rst = 1'b1;
        tick(2);
        mon_clear();
        start_seq(16'h0500, 16'h0600, 8'd1);
        wait_done("t5", 200);
        check_seq("t5", 16'h0500, 16'h0600, 1);
        tb_check("t5_n_start", 64'(n_start), 64'd1);
        tb_check("t5_n_end",   64'(n_end),   64'd1);
        tb_check("t5_run_len", 64'(last_run), 64'd31);
        tb_check("t5_err",     64'(err),     64'd0);
        $display("[TB] T5 reset mid-RUN then clean run: reads=%0d", n_rd);

        // res_valid dropped mid-RUN sets sticky err until next accepted start
        mon_clear();
        start_seq(16'h0100, 16'h0200, 8'd1);
        tb_check("t6_err_before", 64'(err), 64'd0);
        tick(19);
        force_res_low = 1'b1;
        tick(2);
        force_res_low = 1'b0;
        tick(1);
        tb_check("t6_err_set", 64'(err), 64'd1);
        wait_done("t6", 200);
        tb_check("t6_err_sticky", 64'(err),    64'd1);
        tb_check("t6_n_end",      64'(n_end),  64'd1);
        mon_clear();
        start_seq(16'h0100, 16'h0200, 8'd1);
        tb_check("t6_err_cleared", 64'(err), 64'd0);
        wait_done("t6b", 200);
        tb_check("t6_err_clean", 64'(err), 64'd0);
        $display("[TB] T6 res_valid drop flagged and cleared");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
